// File: rtl/clock_failover_controller.sv
// clock_failover_controller
// Watches the two inputs of a glitch-free clock mux from an always-running
// reference clock and decides which one the mux should select. A source is
// declared dead after a run of silent reference cycles. It is declared alive
// again after a run of closely spaced edges. In automatic mode the select
// moves away from a dead preferred source and returns once it recovers.
// Successive select changes are spaced by a hold-off window so the mux can
// settle between switches.
module clock_failover_controller #(
  parameter int STAGES         = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RECOVERY_EDGES = 8,
  parameter int HOLDOFF_CYCLES = 32
) (
  input  logic clock,
  input  logic resetn,
  input  logic clock_0_monitored,
  input  logic clock_1_monitored,
  input  logic preferred,
  input  logic auto_enable,
  output logic select,
  output logic clock_0_alive,
  output logic clock_1_alive,
  output logic both_dead,
  output logic failover
);

  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RECOVERY_EDGES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [SW-1:0] SIL_MAX   = SW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SIL_LAST  = SW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] REC_LAST  = RW'(RECOVERY_EDGES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

  logic [1:0]        mon_in;
  logic [STAGES-1:0] sync_q    [2];
  logic [STAGES-1:0] sync_d    [2];
  logic [1:0]        hist_q, hist_d;
  logic [1:0]        edge_det;
  logic [1:0]        timeout_hit;
  logic [SW-1:0]     silence_q [2];
  logic [SW-1:0]     silence_d [2];
  logic [RW-1:0]     recov_q   [2];
  logic [RW-1:0]     recov_d   [2];
  logic [1:0]        alive_q, alive_d;
  logic              select_q, select_d;
  logic              failover_q, failover_d;
  logic [HW-1:0]     holdoff_q, holdoff_d;
  logic              target;
  logic              do_switch;

  assign mon_in = {clock_1_monitored, clock_0_monitored};

  // Per source: synchronize, detect either polarity of edge, and track
  // silence and recovery runs to decide the alive status.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i]      = {sync_q[i][STAGES-2:0], mon_in[i]};
      hist_d[i]      = sync_q[i][STAGES-1];
      edge_det[i]    = sync_q[i][STAGES-1] != hist_q[i];
      timeout_hit[i] = !edge_det[i] && (silence_q[i] == SIL_LAST);
      silence_d[i]   = silence_q[i];
      recov_d[i]     = recov_q[i];
      alive_d[i]     = alive_q[i];
      if (edge_det[i]) begin
        silence_d[i] = '0;
      end else if (silence_q[i] != SIL_MAX) begin
        silence_d[i] = silence_q[i] + 1'b1;
      end
      if (timeout_hit[i]) begin
        alive_d[i] = 1'b0;
        recov_d[i] = '0;
      end else if (edge_det[i] && !alive_q[i]) begin
        if (recov_q[i] == REC_LAST) begin
          alive_d[i] = 1'b1;
          recov_d[i] = '0;
        end else begin
          recov_d[i] = recov_q[i] + 1'b1;
        end
      end
    end
  end

  // Choose the wanted source and move select toward it once hold-off is over.
  always_comb begin
    target = select_q;
    if (!auto_enable) begin
      target = preferred;
    end else if (alive_q[preferred]) begin
      target = preferred;
    end else if (alive_q[~preferred]) begin
      target = ~preferred;
    end
    do_switch  = (target != select_q) && (holdoff_q == '0);
    select_d   = do_switch ? target : select_q;
    failover_d = do_switch && auto_enable && (target != preferred);
    holdoff_d  = holdoff_q;
    if (do_switch) begin
      holdoff_d = HOLD_LOAD;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]    <= '0;
        silence_q[i] <= '0;
        recov_q[i]   <= '0;
      end
      hist_q     <= '0;
      alive_q    <= '0;
      select_q   <= 1'b0;
      failover_q <= 1'b0;
      holdoff_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]    <= sync_d[i];
        silence_q[i] <= silence_d[i];
        recov_q[i]   <= recov_d[i];
      end
      hist_q     <= hist_d;
      alive_q    <= alive_d;
      select_q   <= select_d;
      failover_q <= failover_d;
      holdoff_q  <= holdoff_d;
    end
  end

  assign select        = select_q;
  assign clock_0_alive = alive_q[0];
  assign clock_1_alive = alive_q[1];
  assign both_dead     = ~|alive_q;
  assign failover      = failover_q;

endmodule

// File: tb/tb_clock_failover_controller.sv
// Randomized bench for clock_failover_controller. The monitored clocks are
// driven on the falling reference edge with random half-periods and on/off
// phases. A timestamp-based reference model predicts every change of the
// output tuple and queues it with its cycle number. A monitor consumes one
// entry per observed DUT output change.
`timescale 1ns/1ps
module tb_clock_failover_controller;

  localparam int STAGES   = 2;
  localparam int TIMEOUT  = 16;
  localparam int RECOVERY = 8;
  localparam int HOLDOFF  = 32;
  localparam logic [4:0] RESET_OUTS = 5'b00010;

  logic       clock       = 1'b0;
  logic       resetn      = 1'b0;
  logic [1:0] mon         = 2'b00;
  logic       preferred   = 1'b0;
  logic       auto_enable = 1'b0;
  logic       select, clock_0_alive, clock_1_alive, both_dead, failover;

  clock_failover_controller #(
    .STAGES(STAGES), .TIMEOUT_CYCLES(TIMEOUT),
    .RECOVERY_EDGES(RECOVERY), .HOLDOFF_CYCLES(HOLDOFF)
  ) dut (
    .clock(clock), .resetn(resetn),
    .clock_0_monitored(mon[0]), .clock_1_monitored(mon[1]),
    .preferred(preferred), .auto_enable(auto_enable),
    .select(select), .clock_0_alive(clock_0_alive), .clock_1_alive(clock_1_alive),
    .both_dead(both_dead), .failover(failover)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   armed  = 1'b0;

  // Reference model state: edges are timestamps, hold-off is "time since last switch".
  logic [1:0] dly[$];
  logic [1:0] m_prev = 2'b00;
  logic [1:0] ev;
  int         last_edge [2];
  int         run       [2];
  logic [1:0] m_alive = 2'b00;
  logic       m_sel = 1'b0;
  logic       m_fo  = 1'b0;
  logic       tgt;
  int         last_switch = -1000000;
  logic [4:0] last_exp = RESET_OUTS;
  logic [4:0] now_outs;

  // Stimulus state.
  int mode [2];
  int cnt  [2];
  int rst_left = 0;
  logic [4:0] dut_last;
  logic [4:0] dut_now;

  task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] want,
                             input int got_cyc, input int want_cyc);
    checks++;
    if (got !== want || got_cyc != want_cyc) begin
      errors++;
      $display("[TB] FAIL %s: got {sel,a0,a1,bd,fo}=%b at cycle %0d, required %b at cycle %0d",
               name, got, got_cyc, want, want_cyc);
    end
  endtask

  function automatic int halfPeriod(input int m);
    case (m)
      1:       return $urandom_range(6, 2);
      2:       return $urandom_range(22, 10);
      3:       return $urandom_range(17, 14);
      default: return 1;
    endcase
  endfunction

  // One reference cycle of input driving, called at the falling edge.
  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      if (mode[i] != 0) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          mon[i] = ~mon[i];
          cnt[i] = halfPeriod(mode[i]);
        end
      end
    end
    if (armed) begin
      if ($urandom_range(59, 0) == 0) preferred = ~preferred;
      if ($urandom_range(199, 0) == 0) auto_enable = ~auto_enable;
      if (rst_left == 0 && $urandom_range(2999, 0) == 0) rst_left = $urandom_range(3, 1);
    end
    if (rst_left > 0) begin
      resetn = 1'b0;
      rst_left--;
    end else begin
      resetn = 1'b1;
    end
  endtask

  // Reference model: predict the output tuple after every rising edge.
  always @(posedge clock) begin
    cycle++;
    if (!resetn) begin
      dly.delete();
      for (int k = 0; k < STAGES; k++) dly.push_back(2'b00);
      m_prev      = 2'b00;
      last_edge   = '{cycle, cycle};
      run         = '{0, 0};
      m_alive     = 2'b00;
      m_sel       = 1'b0;
      m_fo        = 1'b0;
      last_switch = -1000000;
    end else begin
      ev = dly.pop_front();
      dly.push_back(mon ^ m_prev);
      m_prev = mon;
      if (!auto_enable)             tgt = preferred;
      else if (m_alive[preferred])  tgt = preferred;
      else if (m_alive[~preferred]) tgt = ~preferred;
      else                          tgt = m_sel;
      m_fo = 1'b0;
      if (tgt != m_sel && cycle - last_switch >= HOLDOFF) begin
        m_sel       = tgt;
        last_switch = cycle;
        m_fo        = (tgt != preferred);
      end
      for (int i = 0; i < 2; i++) begin
        if (ev[i]) begin
          last_edge[i] = cycle;
          if (!m_alive[i]) begin
            run[i]++;
            if (run[i] == RECOVERY) begin
              m_alive[i] = 1'b1;
              run[i]     = 0;
            end
          end
        end else if (cycle - last_edge[i] == TIMEOUT) begin
          m_alive[i] = 1'b0;
          run[i]     = 0;
        end
      end
    end
    now_outs = {m_sel, m_alive[0], m_alive[1], ~|m_alive, m_fo};
    if (now_outs != last_exp) exp_q.push_back('{cycle, now_outs});
    last_exp = now_outs;
  end

  // Monitor: every change of the DUT output tuple consumes one prediction.
  always @(negedge clock) begin
    exp_t e;
    if (armed) begin
      dut_now = {select, clock_0_alive, clock_1_alive, both_dead, failover};
      if (dut_now !== dut_last) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_change: got %b at cycle %0d, required no change from %b",
                   dut_now, cycle, dut_last);
        end else begin
          e = exp_q.pop_front();
          checkOutput("output_change", dut_now, e.val, cycle, e.cyc);
        end
        dut_last = dut_now;
      end
    end
  end

  initial begin
    int r;
    int len;
    mode        = '{1, 1};
    cnt         = '{3, 2};
    auto_enable = 1'b1;
    preferred   = 1'b0;
    rst_left    = 4;
    repeat (4) begin
      @(negedge clock);
      applyStimulus();
    end
    @(negedge clock);
    checkOutput("reset_state", {select, clock_0_alive, clock_1_alive, both_dead, failover},
                RESET_OUTS, cycle, cycle);
    dut_last = RESET_OUTS;
    armed    = 1'b1;
    applyStimulus();

    for (int ph = 0; ph < 60; ph++) begin
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(9, 0);
        if (ph == 0)     mode[i] = 1;
        else if (r < 2)  mode[i] = 0;
        else if (r < 7)  mode[i] = 1;
        else if (r < 9)  mode[i] = 2;
        else             mode[i] = 3;
        cnt[i] = halfPeriod(mode[i]);
      end
      len = $urandom_range(450, 150);
      for (int c = 0; c < len; c++) begin
        @(negedge clock);
        applyStimulus();
      end
    end

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_changes: got %0d predicted changes never seen, required 0",
               exp_q.size());
    end
    checkOutput("final_state", {select, clock_0_alive, clock_1_alive, both_dead, failover},
                last_exp, cycle, cycle);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
